compuertas_input_conditioner: RTL and testbench

Upstream input stage for the two-input logic-gate block. Takes raw board switches sw0/sw1, synchronizes and debounces them, and drives clean e0/e1 operands. An auto-sweep mode cycles {e1,e0} through 00→01→10→11 for hands-free truth-table demonstration. Also emits a one-cycle change strobe for downstream capture and display logic.

---
 rtl/compuertas_pkg.sv | 17 +
 rtl/compuertas_input_conditioner_debouncer.sv | 71 +++++++
 rtl/compuertas_input_conditioner.sv | 153 +++++++++++++++
 tb/tb_compuertas_input_conditioner.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/compuertas_pkg.sv
// ---------------------------------------------------------------------------
// compuertas_pkg
//   Shared types and constants for the logic-gate input stage.
//   - mode_e      : operand source, MANUAL (debounced switches) or AUTO
//                   (truth-table sweep).
//   - SYNC_STAGES : depth of every asynchronous-input synchronizer.
// ---------------------------------------------------------------------------
package compuertas_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/compuertas_input_conditioner_debouncer.sv
// ---------------------------------------------------------------------------
// switch_debouncer
//   Brings one asynchronous board switch into the clk domain and filters it.
//   The synchronized level must disagree with the accepted (stable) level on
//   DEBOUNCE_CYCLES consecutive edges before it is accepted; any agreement in
//   between restarts the count from zero.
//
//   Latency: raw first sampled at edge n -> stable_o updates at edge
//   n+1+DEBOUNCE_CYCLES.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   raw_i    in   asynchronous raw switch level
//   stable_o out  debounced level (registered)
// ---------------------------------------------------------------------------
module switch_debouncer
  import compuertas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Synchronizer shift register: bit 0 catches the raw pin, MSB is the
  // metastability-safe copy used by the filter.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_bit == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      // Disagreement has persisted long enough: accept and rearm.
      stable_d = sync_bit;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/compuertas_input_conditioner.sv
// ---------------------------------------------------------------------------
// compuertas_input_conditioner
//   Front end of the two-input logic-gate block. Produces clean operands
//   e0/e1 either from two debounced board switches (MANUAL) or from a
//   free-running sweep 00->01->10->11 (AUTO), plus a one-cycle strobe after
//   every operand change.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sw0_raw    in   asynchronous switch for operand e0
//   sw1_raw    in   asynchronous switch for operand e1
//   auto_mode  in   asynchronous level, 1 = sweep, 0 = manual
//   e0, e1     out  conditioned operands (registered)
//   chg        out  pulses one cycle after an edge that changed {e1,e0}
//   sweep_idx  out  current sweep combination, 0 while in MANUAL
// ---------------------------------------------------------------------------
module compuertas_input_conditioner
  import compuertas_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SWEEP_CYCLES    = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw0_raw,
  input  logic       sw1_raw,
  input  logic       auto_mode,
  output logic       e0,
  output logic       e1,
  output logic       chg,
  output logic [1:0] sweep_idx
);

  localparam int SW = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;
  localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEP_CYCLES - 1);

  // -------------------------------------------------------------------------
  // Switch conditioning
  // -------------------------------------------------------------------------
  logic stable0, stable1;

  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb0 (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (sw0_raw),
    .stable_o (stable0)
  );

  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb1 (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (sw1_raw),
    .stable_o (stable1)
  );

  // Mode select is a deliberate level, so it is synchronized but not
  // filtered; a bouncing mode switch just re-enters AUTO at index 0.
  logic [SYNC_STAGES-1:0] auto_sync_q;
  logic                   auto_sync;

  always_ff @(posedge clk) begin
    if (rst) auto_sync_q <= '0;
    else     auto_sync_q <= {auto_sync_q[SYNC_STAGES-2:0], auto_mode};
  end

  assign auto_sync = auto_sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Mode FSM and sweep counter
  // -------------------------------------------------------------------------
  mode_e         state_q, state_d;
  logic [SW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    unique case (state_q)
      MANUAL: begin
        if (auto_sync) begin
          state_d = AUTO;
          tick_d  = '0;
          idx_d   = 2'd0;
        end
      end
      AUTO: begin
        // Leaving AUTO takes priority over a coincident wrap.
        if (!auto_sync) begin
          state_d = MANUAL;
          tick_d  = '0;
          idx_d   = 2'd0;
        end else if (tick_q == SWEEP_LAST) begin
          tick_d = '0;
          idx_d  = idx_q + 2'd1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: begin
        state_d = MANUAL;
        tick_d  = '0;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MANUAL;
      tick_q  <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  // Operand source follows the registered state, so the operands lag a mode
  // change by one edge. Debouncing keeps running in AUTO, so on return to
  // MANUAL the current switch levels appear immediately.
  logic [1:0] e_q, e_d;
  logic [1:0] e_prev_q;
  logic       chg_q, chg_d;

  always_comb begin
    e_d   = (state_q == AUTO) ? idx_q : {stable1, stable0};
    chg_d = (e_q != e_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_q      <= 2'b00;
      e_prev_q <= 2'b00;
      chg_q    <= 1'b0;
    end else begin
      e_q      <= e_d;
      e_prev_q <= e_q;
      chg_q    <= chg_d;
    end
  end

  assign e0        = e_q[0];
  assign e1        = e_q[1];
  assign chg       = chg_q;
  assign sweep_idx = idx_q;

endmodule

// File: tb/tb_compuertas_input_conditioner.sv
module tb_compuertas_input_conditioner;

  localparam int D = 4;
  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw0_raw = 1'b0, sw1_raw = 1'b0, auto_mode = 1'b0;
  logic       e0, e1, chg;
  logic [1:0] sweep_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  compuertas_input_conditioner #(.DEBOUNCE_CYCLES(D), .SWEEP_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw0_raw   (sw0_raw),
    .sw1_raw   (sw1_raw),
    .auto_mode (auto_mode),
    .e0        (e0),
    .e1        (e1),
    .chg       (chg),
    .sweep_idx (sweep_idx)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (behavioural) ----------------
  // h*[0] = sample taken at the last edge, h*[1] = the one before; the
  // filter at edge k sees the level sampled at edge k-2.
  bit   h0 [2], h1 [2], ha [2];
  bit   m_st0, m_st1;      // accepted switch levels
  int   m_run0, m_run1;    // edges of continuous disagreement
  bit   m_auto;
  int   m_ticks;           // edges spent in AUTO since entry
  bit [1:0] m_idx, m_e, m_eprev;
  bit   m_chg;

  task automatic deb(input bit u, inout bit st, inout int run);
    if (u == st) run = 0;
    else begin
      run++;
      if (run == D) begin st = u; run = 0; end
    end
  endtask

  task automatic model_edge();
    bit u0, u1, ua;
    bit [1:0] e_new;
    bit c_new;
    u0 = h0[1]; u1 = h1[1]; ua = ha[1];
    e_new = m_auto ? m_idx : {m_st1, m_st0};
    c_new = (m_e != m_eprev);
    if (rst) begin
      h0 = '{0, 0}; h1 = '{0, 0}; ha = '{0, 0};
      m_st0 = 0; m_st1 = 0; m_run0 = 0; m_run1 = 0;
      m_auto = 0; m_ticks = 0; m_idx = 0;
      m_e = 0; m_eprev = 0; m_chg = 0;
      return;
    end
    m_eprev = m_e; m_e = e_new; m_chg = c_new;
    deb(u0, m_st0, m_run0);
    deb(u1, m_st1, m_run1);
    if (ua) begin
      if (!m_auto) m_ticks = 0;
      else         m_ticks++;
      m_idx  = 2'((m_ticks / S) % 4);
      m_auto = 1;
    end else begin
      m_auto = 0; m_ticks = 0; m_idx = 0;
    end
    h0[1] = h0[0]; h0[0] = sw0_raw;
    h1[1] = h1[0]; h1[0] = sw1_raw;
    ha[1] = ha[0]; ha[0] = auto_mode;
  endtask

  task automatic check(input string tag);
    logic [4:0] got, exp;
    got = {e1, e0, chg, sweep_idx};
    exp = {m_e[1], m_e[0], m_chg, m_idx};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d {e1,e0,chg,idx} got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  // One clock: model and DUT see identical inputs at the edge, compare on
  // the falling edge, then the caller may change inputs.
  task automatic step(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      model_edge();
      @(negedge clk);
      check(tag);
    end
  endtask

  initial begin
    int guard;
    int pulses;
    @(negedge clk);

    // 1. reset with all raw inputs high
    rst = 1; sw0_raw = 1; sw1_raw = 1; auto_mode = 0;
    step(3, "reset");
    rst = 0;
    step(12, "post_reset");

    // 2. sw0 rise with sw1 low
    sw0_raw = 0; sw1_raw = 0;
    step(10, "settle_low");
    sw0_raw = 1;
    step(10, "sw0_rise");

    // 3. short glitch on sw1 must be rejected
    sw1_raw = 1;
    step(3, "glitch_hi");
    sw1_raw = 0;
    step(10, "glitch_lo");
    total++;
    assert (e1 === 1'b0) else begin
      bad++; $error("FAIL glitch_e1 got=%b exp=0", e1);
    end

    // 4. sweep through all combinations and wrap
    auto_mode = 1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, "sweep");
      if (chg) pulses++;
    end
    total++;
    assert (pulses >= 4) else begin
      bad++; $error("FAIL sweep_pulses got=%0d exp>=4", pulses);
    end

    // 5. leave AUTO while index 2 is showing, switches sw0=1 sw1=0
    guard = 0;
    while (!(m_auto && m_idx == 2) && guard < 40) begin
      step(1, "wait_idx2");
      guard++;
    end
    total++;
    assert (guard < 40) else begin
      bad++; $error("FAIL wait_idx2 timeout got=%0d exp<40", guard);
    end
    auto_mode = 0;
    step(8, "auto_exit");
    total++;
    assert ({e1, e0} === 2'b01) else begin
      bad++; $error("FAIL exit_manual got=%b exp=01", {e1, e0});
    end

    // 6. reset during sw1 debounce forces a full recount
    sw1_raw = 1;
    guard = 0;
    while (m_run1 != 2 && guard < 20) begin
      step(1, "wait_cnt2");
      guard++;
    end
    total++;
    assert (guard < 20) else begin
      bad++; $error("FAIL wait_cnt2 timeout got=%0d exp<20", guard);
    end
    rst = 1;
    step(1, "mid_rst");
    rst = 0;
    step(14, "recount");

    // 7. randomized traffic, slow enough for some accepts, fast enough for
    //    glitches, with occasional resets and mode flips
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) sw0_raw = ~sw0_raw;
      if ($urandom_range(0, 5) == 0) sw1_raw = ~sw1_raw;
      if ($urandom_range(0, 25) == 0) auto_mode = ~auto_mode;
      rst = ($urandom_range(0, 120) == 0);
      step(1, "random");
    end
    rst = 0;
    step(5, "tail");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
